// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side queue for the uart core. Detects each completed
//               reception (falling edge of the core's busy flag), captures the
//               received word with its error flag, and queues both in a
//               first-word-fall-through FIFO. The consumer reads the queue
//               through a valid/ready handshake. The block also keeps a sticky
//               overflow flag and a saturating count of errored words.
//
// Ports       : i_clk        system clock, shared with the uart core
//               i_rst        asynchronous active-high reset
//               i_rx_busy    core receiver busy flag
//               i_rx_data    core received word
//               i_rx_error   core parity / stop-bit error flag
//               o_data       head-of-queue word (valid only when o_valid=1)
//               o_data_err   error flag stored with the head word
//               o_valid      queue non-empty
//               i_ready      consumer takes the head word when o_valid=1
//               o_count      current occupancy, 0..G_DEPTH
//               o_overflow   sticky: a word was lost because the queue was full
//               o_err_count  saturating count of errored words received
//               i_clr_status synchronous clear of o_overflow / o_err_count
//
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int G_WORD_WIDTH   = 8,
    parameter int G_DEPTH        = 16,
    parameter int G_DROP_ERRORED = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rx_busy,
    input  logic [G_WORD_WIDTH-1:0]     i_rx_data,
    input  logic                        i_rx_error,
    output logic [G_WORD_WIDTH-1:0]     o_data,
    output logic                        o_data_err,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [$clog2(G_DEPTH):0]    o_count,
    output logic                        o_overflow,
    output logic [7:0]                  o_err_count,
    input  logic                        i_clr_status
);

    localparam int C_AW = $clog2(G_DEPTH);
    localparam int C_CW = C_AW + 1;
    localparam logic [C_CW-1:0] C_DEPTH   = C_CW'(G_DEPTH);
    localparam logic [7:0]      C_ERR_MAX = 8'hFF;

    // Each entry holds {error flag, data word}.
    logic [G_WORD_WIDTH:0] r_mem [G_DEPTH];

    logic                  r_busy_q;
    logic [C_AW-1:0]       r_wr_ptr;
    logic [C_AW-1:0]       r_rd_ptr;
    logic [C_CW-1:0]       r_count;
    logic                  r_overflow;
    logic [7:0]            r_err_count;

    logic                  w_completion;
    logic                  w_err_evt;
    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_evt;

    // The core drops busy in the same cycle it updates data and error, so the
    // word is sampled on the cycle where the delayed busy is still high.
    assign w_completion = r_busy_q & ~i_rx_busy;
    assign w_err_evt    = w_completion & i_rx_error;
    assign w_push_req   = w_completion & ~((G_DROP_ERRORED != 0) & i_rx_error);

    // o_valid comes only from the registered count, so i_ready never reaches
    // o_valid combinationally. An empty queue never pops, so there is no
    // same-cycle bypass of a word being written.
    assign o_valid    = (r_count != '0);
    assign w_pop      = o_valid & i_ready;

    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_push     = w_push_req & ((r_count < C_DEPTH) | w_pop);
    assign w_ovf_evt  = w_push_req & ~w_push;

    // Completion detector and queue pointers / occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy_q <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_busy_q <= i_rx_busy;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset: stale entries are never
    // visible because o_valid gates them.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_rx_error, i_rx_data};
        end
    end

    // Status: a new event in the clearing cycle wins over the clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            if (i_clr_status) begin
                r_overflow  <= w_ovf_evt;
                r_err_count <= w_err_evt ? 8'd1 : 8'd0;
            end else begin
                if (w_ovf_evt) begin
                    r_overflow <= 1'b1;
                end
                if (w_err_evt && (r_err_count != C_ERR_MAX)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign o_data      = r_mem[r_rd_ptr][G_WORD_WIDTH-1:0];
    assign o_data_err  = r_mem[r_rd_ptr][G_WORD_WIDTH];
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. Instance A keeps errored
//               words, instance B drops them; both see the same stimulus.
//               Single-cycle vectors come from a table, multi-cycle corner
//               cases (ordering/wrap, overflow, async reset, saturation) are
//               hand-written sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_busy;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       ready;
    logic       clr;

    logic [7:0] a_data;
    logic       a_err;
    logic       a_valid;
    logic [4:0] a_count;
    logic       a_ovf;
    logic [7:0] a_errcnt;

    logic [7:0] b_data;
    logic       b_err;
    logic       b_valid;
    logic [4:0] b_count;
    logic       b_ovf;
    logic [7:0] b_errcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.G_WORD_WIDTH(8), .G_DEPTH(16), .G_DROP_ERRORED(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx_busy(rx_busy), .i_rx_data(rx_data),
        .i_rx_error(rx_error), .o_data(a_data), .o_data_err(a_err),
        .o_valid(a_valid), .i_ready(ready), .o_count(a_count),
        .o_overflow(a_ovf), .o_err_count(a_errcnt), .i_clr_status(clr)
    );

    uart_rx_fifo #(.G_WORD_WIDTH(8), .G_DEPTH(16), .G_DROP_ERRORED(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx_busy(rx_busy), .i_rx_data(rx_data),
        .i_rx_error(rx_error), .o_data(b_data), .o_data_err(b_err),
        .o_valid(b_valid), .i_ready(ready), .o_count(b_count),
        .o_overflow(b_ovf), .o_err_count(b_errcnt), .i_clr_status(clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One reception: two busy cycles, then busy falls with data/error.
    // Returns at the negedge that starts the completion cycle.
    task automatic frame(input logic [7:0] d, input logic e,
                         input logic rdy_busy, input logic rdy_done);
        @(negedge clk);
        rx_busy = 1'b1;
        ready   = rdy_busy;
        @(negedge clk);
        @(negedge clk);
        rx_busy  = 1'b0;
        rx_data  = d;
        rx_error = e;
        ready    = rdy_done;
    endtask

    // One clock per vector: inputs applied at a negedge, outputs checked at
    // the following negedge.
    typedef struct {
        logic       busy;
        logic [7:0] data;
        logic       err;
        logic       rdy;
        logic       clr;
        logic       ev;      // A o_valid
        logic [7:0] ed;      // A o_data (checked only when ev)
        logic       ee;      // A o_data_err (checked only when ev)
        logic [4:0] ec;      // A o_count
        logic [7:0] eerr;    // A o_err_count
        logic [4:0] ecb;     // B o_count
        logic [7:0] eerrb;   // B o_err_count
    } vec_t;

    vec_t vecs [11];

    initial begin
        // busy data  err rdy clr | ev ed    ee ec eerr | ecb eerrb
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'd0, 5'd0, 8'd0};
        vecs[1]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 5'd1, 8'd0, 5'd1, 8'd0};
        vecs[2]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'd0, 5'd0, 8'd0};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'd0, 5'd0, 8'd0};
        vecs[4]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 5'd1, 8'd1, 5'd0, 8'd1};
        vecs[5]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 5'd1, 8'd1, 5'd0, 8'd1};
        vecs[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 5'd1, 8'd1, 5'd0, 8'd1};
        vecs[7]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 5'd2, 8'd1, 5'd0, 8'd1};
        vecs[8]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 5'd2, 8'd0, 5'd0, 8'd0};
        vecs[9]  = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 5'd1, 8'd0, 5'd0, 8'd0};
        vecs[10] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'd0, 5'd0, 8'd0};

        rst      = 1'b1;
        rx_busy  = 1'b0;
        rx_data  = 8'h00;
        rx_error = 1'b0;
        ready    = 1'b0;
        clr      = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_valid",  32'(a_valid),  32'd0);
        chk("reset_count",  32'(a_count),  32'd0);
        chk("reset_ovf",    32'(a_ovf),    32'd0);
        chk("reset_errcnt", 32'(a_errcnt), 32'd0);
        rst = 1'b0;

        // ---------------- table: single word, errors, status clear --------
        for (int i = 0; i < 11; i++) begin
            rx_busy  = vecs[i].busy;
            rx_data  = vecs[i].data;
            rx_error = vecs[i].err;
            ready    = vecs[i].rdy;
            clr      = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_data", i), 32'(a_data), 32'(vecs[i].ed));
                chk($sformatf("vec%0d_derr", i), 32'(a_err),  32'(vecs[i].ee));
            end
            chk($sformatf("vec%0d_count", i),   32'(a_count),  32'(vecs[i].ec));
            chk($sformatf("vec%0d_errcnt", i),  32'(a_errcnt), 32'(vecs[i].eerr));
            chk($sformatf("vec%0d_ovf", i),     32'(a_ovf),    32'd0);
            chk($sformatf("vec%0d_b_count", i), 32'(b_count),  32'(vecs[i].ecb));
            chk($sformatf("vec%0d_b_errcnt", i), 32'(b_errcnt), 32'(vecs[i].eerrb));
        end
        clr   = 1'b0;
        ready = 1'b0;

        // ---------------- ordering and pointer wrap, ready held high -------
        for (int i = 0; i < 20; i++) begin
            frame(8'(i), 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("order%0d_valid", i), 32'(a_valid), 32'd1);
            chk($sformatf("order%0d_data", i),  32'(a_data),  32'(i));
            chk($sformatf("order%0d_count", i), 32'(a_count), 32'd1);
        end
        @(negedge clk);
        chk("order_end_count", 32'(a_count), 32'd0);
        chk("order_end_ovf",   32'(a_ovf),   32'd0);
        ready = 1'b0;

        // ---------------- overflow -----------------------------------------
        for (int i = 0; i < 17; i++) begin
            frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("ovf_count", 32'(a_count), 32'd16);
        chk("ovf_flag",  32'(a_ovf),   32'd1);
        chk("ovf_head",  32'(a_data),  32'h40);
        // 18th word arrives together with a pop of the full queue.
        frame(8'h51, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        ready = 1'b0;
        chk("ovf_pushpop_count", 32'(a_count), 32'd16);
        chk("ovf_pushpop_head",  32'(a_data),  32'h41);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(a_valid), 32'd1);
            chk($sformatf("drain%0d_data", k),  32'(a_data),
                (k < 15) ? 32'h41 + 32'(k) : 32'h51);
            ready = 1'b1;
            @(negedge clk);
        end
        ready = 1'b0;
        chk("drain_end_valid", 32'(a_valid), 32'd0);
        chk("drain_end_count", 32'(a_count), 32'd0);
        chk("drain_end_ovf",   32'(a_ovf),   32'd1);

        // ---------------- async reset mid-operation ------------------------
        for (int i = 0; i < 5; i++) begin
            frame(8'h60 + 8'(i), (i == 2), 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("prerst_count",  32'(a_count),  32'd5);
        chk("prerst_errcnt", 32'(a_errcnt), 32'd1);
        rx_busy  = 1'b1;
        rx_error = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",  32'(a_valid),  32'd0);
        chk("arst_count",  32'(a_count),  32'd0);
        chk("arst_ovf",    32'(a_ovf),    32'd0);
        chk("arst_errcnt", 32'(a_errcnt), 32'd0);
        rx_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("postrst_count", 32'(a_count), 32'd0);
        chk("postrst_valid", 32'(a_valid), 32'd0);
        frame(8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("postrst_frame_valid", 32'(a_valid), 32'd1);
        chk("postrst_frame_data",  32'(a_data),  32'h77);
        chk("postrst_frame_count", 32'(a_count), 32'd1);

        // ---------------- error-count saturation ---------------------------
        for (int i = 0; i < 260; i++) begin
            frame(8'hE0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rx_error = 1'b0;
        chk("sat_a_errcnt", 32'(a_errcnt), 32'd255);
        chk("sat_b_errcnt", 32'(b_errcnt), 32'd255);
        chk("sat_b_count",  32'(b_count),  32'd1);
        chk("sat_a_ovf",    32'(a_ovf),    32'd1);
        chk("sat_a_count",  32'(a_count),  32'd16);

        // ---------------- idle status clear --------------------------------
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_idle_ovf",    32'(a_ovf),    32'd0);
        chk("clr_idle_errcnt", 32'(a_errcnt), 32'd0);
        chk("clr_idle_count",  32'(a_count),  32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
